// File: rtl/cache_pkg.sv
// Shared constants for the cache miss controller: FSM state encodings,
// default widths and the word-alignment of memory addresses.
package cache_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 32;

    // Memory is word addressed; the two byte-offset bits are forced to this value.
    localparam logic [1:0] WORD_ALIGN_LSBS = 2'b00;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RD_REQ  = 3'd1;
    localparam state_t ST_RD_WAIT = 3'd2;
    localparam state_t ST_RD_DONE = 3'd3;
    localparam state_t ST_WR_REQ  = 3'd4;
    localparam state_t ST_WR_WAIT = 3'd5;
    localparam state_t ST_WR_DONE = 3'd6;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_miss_controller.sv
// Blocking miss handler for a write-through, no-write-allocate data cache:
// stalls the CPU, runs one memory transaction and refills the cache on loads.
module cache_miss_controller
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    input  logic                  cache_hit_i,
    input  logic [DATA_WIDTH-1:0] cache_data_i,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  fill_o,
    output logic [ADDR_WIDTH-1:0] fill_addr_o,
    output logic [DATA_WIDTH-1:0] fill_data_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [CNT_WIDTH-1:0]  miss_cnt_o,
    output logic [2:0]            dbg_state_o
);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [DATA_WIDTH-1:0] line_buf;
    logic                  cap_hit;
    logic                  idle_req, load_hit, load_miss, store_req;
    logic                  busy, rd_done, wr_fill;

    // New CPU requests are only decoded in IDLE and never while reset is asserted.
    assign idle_req  = rst_n && (state == ST_IDLE) && cpu_req_i;
    assign load_hit  = idle_req && !cpu_we_i && cache_hit_i;
    assign load_miss = idle_req && !cpu_we_i && !cache_hit_i;
    assign store_req = idle_req && cpu_we_i;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load_miss)      state_nxt = ST_RD_REQ;
                else if (store_req) state_nxt = ST_WR_REQ;
            end
            ST_RD_REQ:  if (mem_gnt_i)    state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: if (mem_rvalid_i) state_nxt = ST_RD_DONE;
            ST_RD_DONE: state_nxt = ST_IDLE;
            ST_WR_REQ:  if (mem_gnt_i)    state_nxt = ST_WR_WAIT;
            ST_WR_WAIT: if (mem_rvalid_i) state_nxt = ST_WR_DONE;
            ST_WR_DONE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_hit   <= 1'b0;
            line_buf  <= '0;
        end else begin
            state <= state_nxt;
            if (load_miss || store_req) begin
                cap_addr  <= cpu_addr_i;
                cap_wdata <= cpu_wdata_i;
                cap_hit   <= cache_hit_i;
            end
            if ((state == ST_RD_WAIT) && mem_rvalid_i) begin
                line_buf <= mem_rdata_i;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (load_miss),
        .count (miss_cnt_o)
    );

    // Memory handshake: mem_req_o and its fields stay constant until a rising
    // edge sees mem_gnt_i=1; the single response is mem_rvalid_i in the WAIT state.
    assign busy    = (state == ST_RD_REQ) || (state == ST_RD_WAIT) ||
                     (state == ST_WR_REQ) || (state == ST_WR_WAIT);
    assign rd_done = (state == ST_RD_DONE);
    assign wr_fill = (state == ST_WR_DONE) && cap_hit;

    assign stall_o     = busy || load_miss || store_req;
    assign cpu_rdata_o = load_hit ? cache_data_i : (rd_done ? line_buf : '0);

    assign fill_o      = rd_done || wr_fill;
    assign fill_addr_o = fill_o ? cap_addr : '0;
    assign fill_data_o = rd_done ? line_buf : (wr_fill ? cap_wdata : '0);

    assign mem_req_o   = (state == ST_RD_REQ) || (state == ST_WR_REQ);
    assign mem_we_o    = (state == ST_WR_REQ);
    assign mem_addr_o  = mem_req_o ? {cap_addr[ADDR_WIDTH-1:2], WORD_ALIGN_LSBS} : '0;
    assign mem_wdata_o = mem_we_o ? cap_wdata : '0;

    assign dbg_state_o = state;

endmodule

// File: tb/tb_cache_miss_controller.sv
// Self-checking bench for cache_miss_controller; a second instance with a
// 2-bit miss counter checks saturation.
module tb_cache_miss_controller;
    import cache_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk, rst_n;
    logic          cpu_req, cpu_we, cache_hit;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cache_data;
    logic          mem_gnt, mem_rvalid;
    logic [DW-1:0] mem_rdata;

    logic          stall, fill, mem_req, mem_we;
    logic [DW-1:0] cpu_rdata, fill_data, mem_wdata;
    logic [AW-1:0] fill_addr, mem_addr;
    logic [15:0]   miss_cnt;
    logic [2:0]    state;

    logic          b_stall, b_fill, b_mem_req, b_mem_we;
    logic [DW-1:0] b_cpu_rdata, b_fill_data, b_mem_wdata;
    logic [AW-1:0] b_fill_addr, b_mem_addr;
    logic [1:0]    b_miss_cnt;
    logic [2:0]    b_state;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_v;

    cache_miss_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cache_hit_i(cache_hit),
        .cache_data_i(cache_data), .stall_o(stall), .cpu_rdata_o(cpu_rdata),
        .fill_o(fill), .fill_addr_o(fill_addr), .fill_data_o(fill_data),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .miss_cnt_o(miss_cnt), .dbg_state_o(state)
    );

    cache_miss_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cache_hit_i(cache_hit),
        .cache_data_i(cache_data), .stall_o(b_stall), .cpu_rdata_o(b_cpu_rdata),
        .fill_o(b_fill), .fill_addr_o(b_fill_addr), .fill_data_o(b_fill_data),
        .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .miss_cnt_o(b_miss_cnt), .dbg_state_o(b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        cache_hit = 0; cache_data = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    // Inputs change at negedge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #12;
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state, ST_IDLE); end
        total++; if (miss_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", miss_cnt); end
        total++; if ({stall, mem_req, fill} !== 3'b000) begin bad++; $display("FAIL reset_ctrl got=%b exp=000", {stall, mem_req, fill}); end
        total++; if (cpu_rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
        next_cycle();
        rst_n = 1;
    endtask

    task automatic test_load_hit();
        next_cycle();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40; cache_hit = 1; cache_data = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL hit_stall got=%b exp=0", stall); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL hit_memreq got=%b exp=0", mem_req); end
        exp_v = exp_q.pop_front();
        total++; if (cpu_rdata !== exp_v) begin bad++; $display("FAIL hit_rdata got=%h exp=%h", cpu_rdata, exp_v); end
        next_cycle();
        idle_inputs();
        #1;
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL hit_state got=%0d exp=%0d", state, ST_IDLE); end
        total++; if (cpu_rdata !== '0) begin bad++; $display("FAIL hit_rdata_idle got=%h exp=0", cpu_rdata); end
    endtask

    task automatic test_load_miss();
        int stalls;
        stalls = 0;
        next_cycle();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h83; cache_hit = 0;
        exp_q.push_back(32'h12345678);
        #1;
        if (stall) stalls++;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL miss_idle_memreq got=%b exp=0", mem_req); end
        // RD_REQ: CPU inputs wander, a spurious rvalid arrives with the grant
        next_cycle();
        cpu_req = 0; cpu_addr = 32'hFFFF_FFF0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
        #1;
        if (stall) stalls++;
        total++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h80}) begin bad++; $display("FAIL miss_req got=%b%b %h exp=10 00000080", mem_req, mem_we, mem_addr); end
        total++; if (miss_cnt !== 16'd1) begin bad++; $display("FAIL miss_cnt got=%0d exp=1", miss_cnt); end
        next_cycle();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h12345678;
        #1;
        if (stall) stalls++;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL miss_wait_memreq got=%b exp=0", mem_req); end
        next_cycle();
        mem_rvalid = 0; mem_rdata = '0;
        #1;
        total++; if (stalls !== 3) begin bad++; $display("FAIL miss_stalls got=%0d exp=3", stalls); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL miss_done_stall got=%b exp=0", stall); end
        total++; if ({fill, fill_addr, fill_data} !== {1'b1, 32'h83, 32'h12345678}) begin bad++; $display("FAIL miss_fill got=%b %h %h exp=1 00000083 12345678", fill, fill_addr, fill_data); end
        exp_v = exp_q.pop_front();
        total++; if (cpu_rdata !== exp_v) begin bad++; $display("FAIL miss_rdata got=%h exp=%h", cpu_rdata, exp_v); end
        next_cycle();
        #1;
        total++; if ({state, fill, fill_addr, cpu_rdata} !== {ST_IDLE, 1'b0, 32'h0, 32'h0}) begin bad++; $display("FAIL miss_after got=%0d %b %h %h", state, fill, fill_addr, cpu_rdata); end
    endtask

    task automatic test_store(input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                              input logic hit, input int gnt_delay);
        string tag;
        tag = hit ? "st_hit" : "st_miss";
        next_cycle();
        cpu_req = 1; cpu_we = 1; cpu_addr = addr; cpu_wdata = wd; cache_hit = hit;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL %s_stall0 got=%b exp=1", tag, stall); end
        for (int c = 0; c <= gnt_delay; c++) begin
            next_cycle();
            cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cache_hit = 0;
            mem_gnt = (c == gnt_delay);
            #1;
            total++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, stall} !== {1'b1, 1'b1, addr & ~32'h3, wd, 1'b1}) begin
                bad++; $display("FAIL %s_req%0d got=%b%b %h %h stall=%b exp=11 %h %h", tag, c, mem_req, mem_we, mem_addr, mem_wdata, stall, addr & ~32'h3, wd);
            end
        end
        next_cycle();
        mem_gnt = 0; mem_rvalid = 1;
        #1;
        total++; if ({mem_req, stall} !== 2'b01) begin bad++; $display("FAIL %s_wait got=%b%b exp=01", tag, mem_req, stall); end
        next_cycle();
        mem_rvalid = 0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL %s_done_stall got=%b exp=0", tag, stall); end
        total++;
        if ({fill, fill_addr, fill_data} !== (hit ? {1'b1, addr, wd} : {1'b0, 32'h0, 32'h0})) begin
            bad++; $display("FAIL %s_fill got=%b %h %h exp_fill=%b", tag, fill, fill_addr, fill_data, hit);
        end
        total++; if (cpu_rdata !== '0) begin bad++; $display("FAIL %s_rdata got=%h exp=0", tag, cpu_rdata); end
        next_cycle();
        #1;
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL %s_idle got=%0d exp=%0d", tag, state, ST_IDLE); end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h104; cache_hit = 0;
        next_cycle();
        mem_gnt = 1;
        next_cycle();
        mem_gnt = 0;
        #1;
        total++; if (state !== ST_RD_WAIT) begin bad++; $display("FAIL rstmid_pre got=%0d exp=%0d", state, ST_RD_WAIT); end
        #1;
        rst_n = 0;
        #1;
        total++; if ({mem_req, stall, fill} !== 3'b000) begin bad++; $display("FAIL rstmid_ctrl got=%b exp=000", {mem_req, stall, fill}); end
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL rstmid_state got=%0d exp=%0d", state, ST_IDLE); end
        next_cycle();
        idle_inputs();
        rst_n = 1;
        mem_rvalid = 1; mem_rdata = 32'h5A5A5A5A;
        next_cycle();
        mem_rvalid = 0;
        #1;
        total++; if ({state, fill, stall, cpu_rdata} !== {ST_IDLE, 1'b0, 1'b0, 32'h0}) begin bad++; $display("FAIL rstmid_late got=%0d %b %b %h", state, fill, stall, cpu_rdata); end
    endtask

    task automatic load_miss_seq(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int n);
        logic [1:0] exp_sat;
        next_cycle();
        cpu_req = 1; cpu_we = 0; cpu_addr = addr; cache_hit = 0;
        exp_q.push_back(data);
        next_cycle();
        idle_inputs();
        mem_gnt = 1;
        next_cycle();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = data;
        next_cycle();
        mem_rvalid = 0;
        #1;
        exp_v = exp_q.pop_front();
        total++; if (cpu_rdata !== exp_v) begin bad++; $display("FAIL sat_rdata%0d got=%h exp=%h", n, cpu_rdata, exp_v); end
        exp_sat = (n > 3) ? 2'd3 : 2'(n);
        total++; if (b_miss_cnt !== exp_sat) begin bad++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", n, b_miss_cnt, exp_sat); end
        total++; if (miss_cnt !== 16'(n)) begin bad++; $display("FAIL wide_cnt%0d got=%0d exp=%0d", n, miss_cnt, n); end
    endtask

    task automatic test_saturation();
        next_cycle();
        rst_n = 0;
        next_cycle();
        rst_n = 1;
        for (int i = 1; i <= 5; i++) begin
            load_miss_seq(32'h200 + 32'(i * 4), $urandom_range(32'h7FFF_FFFF, 1), i);
        end
        next_cycle();
        #1;
        total++; if (b_miss_cnt !== 2'd3) begin bad++; $display("FAIL sat_hold got=%0d exp=3", b_miss_cnt); end
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_load_hit();
        test_load_miss();
        test_store(32'h10, 32'hCAFEF00D, 1'b1, 4);
        test_store(32'h26, 32'h5555AAAA, 1'b0, 0);
        test_reset_mid();
        test_saturation();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_miss_controller.md
CACHE_MISS_CONTROLLER -- requirements
Module: cache_miss_controller

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: CPU/memory data word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32: byte address width.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16: miss counter width.
REQ-004 The block SHALL have port clk, input, 1: sole clock, rising edge; the block has one clock and its reset is asynchronous, active-low.
REQ-005 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 The block SHALL have port cpu_req_i, input, 1: CPU data access this cycle.
REQ-007 The block SHALL have port cpu_we_i, input, 1: 1 store, 0 load.
REQ-008 The block SHALL have port cpu_addr_i, input, ADDR_WIDTH: access byte address.
REQ-009 The block SHALL have port cpu_wdata_i, input, DATA_WIDTH: store data.
REQ-010 The block SHALL have port cache_hit_i, input, 1: cache hit for cpu_addr_i.
REQ-011 The block SHALL have port cache_data_i, input, DATA_WIDTH: cache read word.
REQ-012 The block SHALL have port stall_o, output, 1: freeze CPU, hold request stable.
REQ-013 The block SHALL have port cpu_rdata_o, output, DATA_WIDTH: load result.
REQ-014 The block SHALL have port fill_o, output, 1: one-cycle cache write strobe.
REQ-015 The block SHALL have ports fill_addr_o, output, ADDR_WIDTH, and fill_data_o, output, DATA_WIDTH: cache write address and data.
REQ-016 The block SHALL have ports mem_req_o, output, 1; mem_we_o, output, 1; mem_addr_o, output, ADDR_WIDTH; mem_wdata_o, output, DATA_WIDTH: memory request.
REQ-017 The block SHALL have ports mem_gnt_i, input, 1 (request accepted); mem_rvalid_i, input, 1 (response); mem_rdata_i, input, DATA_WIDTH.
REQ-018 The block SHALL have port miss_cnt_o, output, CNT_WIDTH: load-miss count.

Function
REQ-019 The FSM SHALL have the states IDLE, RD_REQ, RD_WAIT, RD_DONE, WR_REQ, WR_WAIT and WR_DONE.
REQ-020 In IDLE, for a load with a hit, the block SHALL drive cpu_rdata_o=cache_data_i and stall_o=0 combinationally, with no state change.
REQ-021 In IDLE, for a load with a miss, the block SHALL assert stall_o combinationally, capture addr, go to RD_REQ, and increment miss_cnt_o.
REQ-022 In IDLE, for a store, the block SHALL assert stall_o, capture addr, wdata and the hit flag, and go to WR_REQ.
REQ-023 In RD_REQ and WR_REQ, the block SHALL hold mem_req_o=1 with mem_addr_o, mem_we_o and mem_wdata_o stable until a rising edge with mem_gnt_i=1, then go to RD_WAIT or WR_WAIT.
REQ-024 The block SHALL force mem_addr_o[1:0] to 2'b00.
REQ-025 mem_req_o SHALL be 0 in all other states.
REQ-026 In RD_WAIT, the block SHALL register mem_rdata_i into the line buffer on mem_rvalid_i and go to RD_DONE.
REQ-027 In WR_WAIT, the block SHALL go to WR_DONE on mem_rvalid_i.
REQ-028 In RD_DONE, the block SHALL drive stall_o=0, cpu_rdata_o=buffer and fill_o=1, with fill_addr_o=captured addr and fill_data_o=buffer, then go to IDLE.
REQ-029 In WR_DONE, the block SHALL drive stall_o=0 and fill_o equal to the captured hit flag (write-through, no write-allocate), with fill_data_o=captured wdata, then go to IDLE.
REQ-030 stall_o SHALL be 1 in RD_REQ, RD_WAIT, WR_REQ and WR_WAIT.
REQ-031 Minimum read-miss latency SHALL be 3 stalled cycles, with data in the 4th; minimum store latency SHALL be the same.
REQ-032 The block SHALL ignore mem_rvalid_i outside RD_WAIT/WR_WAIT, including in the grant cycle.
REQ-033 The block SHALL ignore changes to cpu_req_i and cpu_* while not in IDLE, and an in-flight transaction SHALL always complete.
REQ-034 miss_cnt_o SHALL saturate at all-ones and never wrap.
REQ-035 cpu_rdata_o SHALL be 0 when not a load hit and not RD_DONE; fill_addr_o and fill_data_o SHALL be 0 when fill_o=0.

Reset
REQ-036 rst_n=0 SHALL asynchronously force IDLE, miss_cnt_o=0, buffer, captured addr/wdata/hit=0, and mem_req_o=0 and fill_o=0 immediately.
REQ-037 Reset mid-transaction SHALL abandon the transaction, and a later mem_rvalid_i SHALL be ignored.
REQ-038 After reset release, the first rising edge SHALL be able to accept a request.

Structure
REQ-039 Package cache_pkg SHALL hold the FSM state enum, DATA_WIDTH/ADDR_WIDTH defaults and the word-align mask.
REQ-040 Sub-module sat_counter (parameter WIDTH, inc, async active-low reset) SHALL implement miss_cnt_o.

Verification
REQ-041 The bench SHALL cover load hit at 0x40, cache_data_i=0xDEADBEEF -> stall_o=0 same cycle, cpu_rdata_o=0xDEADBEEF, no mem_req_o.
REQ-042 The bench SHALL cover load miss at 0x83, gnt immediate, rvalid next cycle with 0x12345678 -> mem_addr_o=0x80, 3 stall cycles, RD_DONE fill_o=1 with fill_addr_o=0x83 and fill_data_o=0x12345678, miss_cnt_o=1.
REQ-043 The bench SHALL cover store 0xCAFEF00D to 0x10 with hit, gnt delayed 4 cycles -> mem_req_o held 5 cycles with stable fields, WR_DONE fill_o=1.
REQ-044 The bench SHALL cover a store miss -> memory write issued, fill_o=0 in WR_DONE.
REQ-045 The bench SHALL cover rst_n low during RD_WAIT, then a late rvalid -> mem_req_o=0 and stall_o=0 at once, no fill_o, IDLE.
REQ-046 The bench SHALL cover CNT_WIDTH=2 with 5 load misses -> miss_cnt_o reaches 3 and stays 3.
